matrix_lock_arbiter: RTL

MATRIX_LOCK_ARBITER -- requirements
Module: matrix_lock_arbiter

---
 rtl/matrix_lock_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/matrix_lock_arbiter.sv
// Matrix (least-recently-granted) arbiter with priority levels and a locked grant.
// The highest req_prio level among active requestors wins; the precedence matrix
// only breaks ties inside that level. A grant stays locked until its req drops.
// Optional feature: define MATRIX_ARB_TIMEOUT_EN to revoke grants held MAX_HOLD cycles.
module matrix_lock_arbiter #(
  parameter int NUM_REQUESTORS = 4,
  parameter int PRIORITY_WIDTH = 2,
  parameter int MAX_HOLD       = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQUESTORS-1:0]                req,
  input  logic [NUM_REQUESTORS*PRIORITY_WIDTH-1:0] req_prio,
  output logic [NUM_REQUESTORS-1:0]                grant,
  output logic [((NUM_REQUESTORS > 1) ? $clog2(NUM_REQUESTORS) : 1)-1:0] grant_id,
  output logic                                     grant_valid,
  output logic                                     timeout
);

  localparam int N    = NUM_REQUESTORS;
  localparam int PW   = PRIORITY_WIDTH;
  localparam int ID_W = (N > 1) ? $clog2(N) : 1;

  // Out-of-range parameters are rejected when the design is elaborated.
  if ((N < 2) || (N > 32) || (MAX_HOLD < 1) || (MAX_HOLD > 65535)) begin : g_param_check
    $error("matrix_lock_arbiter: parameter out of range");
  end

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                 state, state_n;
  logic [N-1:0][N-1:0]    w, w_n;
  logic [N-1:0]           grant_n;
  logic [ID_W-1:0]        grant_id_n;
  logic [PW-1:0]          max_prio;
  logic [N-1:0]           eligible;
  logic [N-1:0]           winner;
  logic [ID_W-1:0]        winner_id;
  logic                   beats;

`ifdef MATRIX_ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
  logic [15:0]            hold_cnt, hold_cnt_n;
  logic                   timeout_n;
`endif

  // Find the top active priority level, then the matrix winner within that level.
  always_comb begin
    max_prio  = '0;
    eligible  = '0;
    winner    = '0;
    winner_id = '0;
    beats     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (req_prio[i*PW +: PW] > max_prio)) begin
        max_prio = req_prio[i*PW +: PW];
      end
    end
    for (int i = 0; i < N; i++) begin
      eligible[i] = req[i] && (req_prio[i*PW +: PW] == max_prio);
    end
    for (int i = 0; i < N; i++) begin
      beats = eligible[i];
      for (int j = 0; j < N; j++) begin
        if ((j != i) && eligible[j] && !w[i][j]) begin
          beats = 1'b0;
        end
      end
      winner[i] = beats;
      if (beats) begin
        winner_id = ID_W'(i);
      end
    end
  end

  // Next-state logic: issue a grant from IDLE, hold or release it in LOCKED.
  always_comb begin
    state_n    = state;
    grant_n    = grant;
    grant_id_n = grant_id;
    w_n        = w;
`ifdef MATRIX_ARB_TIMEOUT_EN
    hold_cnt_n = hold_cnt;
    timeout_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          state_n    = LOCKED;
          grant_n    = winner;
          grant_id_n = winner_id;
          // The winner loses to everyone from now on: clear its row, set its column.
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              if (winner[i]) begin
                w_n[i][j] = 1'b0;
              end
              if (winner[j] && (i != j)) begin
                w_n[i][j] = 1'b1;
              end
            end
          end
`ifdef MATRIX_ARB_TIMEOUT_EN
          hold_cnt_n = '0;
`endif
        end
      end
      LOCKED: begin
        if (!(|(grant & req))) begin
          state_n    = IDLE;
          grant_n    = '0;
          grant_id_n = '0;
        end
`ifdef MATRIX_ARB_TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST) begin
          state_n    = IDLE;
          grant_n    = '0;
          grant_id_n = '0;
          timeout_n  = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + 16'd1;
        end
`endif
      end
      default: begin
        state_n    = IDLE;
        grant_n    = '0;
        grant_id_n = '0;
      end
    endcase
  end

  // State, grant and precedence registers; reset restores lowest-index-wins order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          w[i][j] <= (i < j);
        end
      end
`ifdef MATRIX_ARB_TIMEOUT_EN
      hold_cnt <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      grant_id <= grant_id_n;
      w        <= w_n;
`ifdef MATRIX_ARB_TIMEOUT_EN
      hold_cnt <= hold_cnt_n;
      timeout  <= timeout_n;
`endif
    end
  end

`ifndef MATRIX_ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  assign grant_valid = |grant;

endmodule
